// File: rtl/bits_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : bits_serializer_if
//  Brief    : Word-in / bit-out handshake bundle for bits_serializer.
//             I_last / O_last exist only with BITS_SERIALIZER_LAST_EN.
//  Revision : 1.0 - initial release
// ============================================================================
interface bits_serializer_if #(
    parameter int M = 8
);
    logic         bypass;
    logic [M-1:0] I;
    logic         I_vld;
    logic         I_rdy;
    logic         O;
    logic         O_vld;
    logic         O_rdy;
`ifdef BITS_SERIALIZER_LAST_EN
    logic         I_last;
    logic         O_last;

    modport master (output bypass, I, I_vld, I_last, O_rdy,
                    input  I_rdy, O, O_vld, O_last);
    modport slave  (input  bypass, I, I_vld, I_last, O_rdy,
                    output I_rdy, O, O_vld, O_last);
`else
    modport master (output bypass, I, I_vld, O_rdy,
                    input  I_rdy, O, O_vld);
    modport slave  (input  bypass, I, I_vld, O_rdy,
                    output I_rdy, O, O_vld);
`endif
endinterface
`default_nettype wire

// File: rtl/bits_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : bits_serializer
//  Brief    : Serialises the low N bits of each word (or one bypass bit) onto
//             a 1-bit valid/ready stream. Optional macro BITS_SERIALIZER_LAST_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module bits_serializer #(
    parameter int N                = 2,
    parameter int M                = 8,
    parameter int LSB_FIRST        = 1,
    parameter int BYPASS_SELECTION = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    bits_serializer_if.slave  bus
);

    localparam int                  c_CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_CNT_W-1:0]  c_LAST_IDX = c_CNT_W'(N - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t               r_state,  w_state_nxt;
    logic [N-1:0]         r_word,   w_word_nxt;
    logic                 r_bypass, w_bypass_nxt;
    logic [c_CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [c_CNT_W-1:0]   r_k_last, w_k_last_nxt;
    logic                 r_o,      w_o_nxt;
    logic                 w_last_bit;
    logic                 w_i_rdy;
    logic                 w_accept;
    logic                 w_xfer;
`ifdef BITS_SERIALIZER_LAST_EN
    logic                 r_last_flag, w_last_flag_nxt;
    logic                 r_o_last,    w_o_last_nxt;
`endif

    generate
        if (M > N) begin : g_unused_msbs
            logic [M-N-1:0] w_unused_msbs;
            assign w_unused_msbs = bus.I[M-1:N];
        end
    endgenerate

    function automatic logic f_pick(input logic [N-1:0]       word,
                                    input logic [c_CNT_W-1:0] cnt,
                                    input logic               byp);
        logic bit_v;
        bit_v = 1'b0;
        for (int b = 0; b < N; b++) begin
            if (byp) begin
                if (b == BYPASS_SELECTION) bit_v = word[b];
            end else if (LSB_FIRST != 0) begin
                if (b == int'(cnt)) bit_v = word[b];
            end else begin
                if (b == N - 1 - int'(cnt)) bit_v = word[b];
            end
        end
        return bit_v;
    endfunction

    assign w_last_bit = (r_cnt == r_k_last);
    // Ready looks through to O_rdy so a new word can follow the last bit gaplessly
    assign w_i_rdy    = rst_n && ((r_state == ST_EMPTY) || (bus.O_rdy && w_last_bit));
    assign w_accept   = bus.I_vld && w_i_rdy;
    assign w_xfer     = (r_state == ST_SHIFT) && bus.O_rdy;

    always_comb begin
        w_state_nxt  = r_state;
        w_word_nxt   = r_word;
        w_bypass_nxt = r_bypass;
        w_cnt_nxt    = r_cnt;
        w_k_last_nxt = r_k_last;
        w_o_nxt      = r_o;
`ifdef BITS_SERIALIZER_LAST_EN
        w_last_flag_nxt = r_last_flag;
`endif
        if (w_accept) begin
            w_state_nxt  = ST_SHIFT;
            w_word_nxt   = bus.I[N-1:0];
            w_bypass_nxt = bus.bypass;
            w_cnt_nxt    = '0;
            w_k_last_nxt = bus.bypass ? '0 : c_LAST_IDX;
            w_o_nxt      = f_pick(bus.I[N-1:0], '0, bus.bypass);
`ifdef BITS_SERIALIZER_LAST_EN
            w_last_flag_nxt = bus.I_last;
`endif
        end else if (w_xfer) begin
            if (w_last_bit) begin
                w_state_nxt = ST_EMPTY;
                w_cnt_nxt   = '0;
                w_o_nxt     = 1'b0;
            end else begin
                w_cnt_nxt   = r_cnt + 1'b1;
                w_o_nxt     = f_pick(r_word, w_cnt_nxt, r_bypass);
            end
        end
`ifdef BITS_SERIALIZER_LAST_EN
        w_o_last_nxt = (w_state_nxt == ST_SHIFT) && w_last_flag_nxt &&
                       (w_cnt_nxt == w_k_last_nxt);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_EMPTY;
            r_word   <= '0;
            r_bypass <= 1'b0;
            r_cnt    <= '0;
            r_k_last <= '0;
            r_o      <= 1'b0;
`ifdef BITS_SERIALIZER_LAST_EN
            r_last_flag <= 1'b0;
            r_o_last    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_word   <= w_word_nxt;
            r_bypass <= w_bypass_nxt;
            r_cnt    <= w_cnt_nxt;
            r_k_last <= w_k_last_nxt;
            r_o      <= w_o_nxt;
`ifdef BITS_SERIALIZER_LAST_EN
            r_last_flag <= w_last_flag_nxt;
            r_o_last    <= w_o_last_nxt;
`endif
        end
    end

    assign bus.I_rdy = w_i_rdy;
    assign bus.O     = r_o;
    assign bus.O_vld = (r_state == ST_SHIFT);
`ifdef BITS_SERIALIZER_LAST_EN
    assign bus.O_last = r_o_last;
`endif

endmodule
`default_nettype wire
